mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request/response port between an
// instruction-fetch requester and a data load/store requester. One
// transaction is in flight at a time. Requests are sampled in IDLE, so the
// memory request appears one cycle after the requester first asks.
// Build option: define ARB_RR_EN for round-robin arbitration on conflict;
// left undefined, data has fixed priority over instruction fetch.
module mem_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   // instruction fetch requester
   input  logic        i_req_valid,
   input  logic [31:0] i_addr,
   output logic        i_req_ack,
   output logic [31:0] i_rdata,
   output logic        i_rdata_valid,
   input  logic        i_rdata_ack,
   // data load/store requester
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_req_ack,
   output logic [31:0] d_rdata,
   output logic        d_rdata_valid,
   input  logic        d_rdata_ack,
   // shared memory port
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_req_ack,
   input  logic [31:0] m_rdata,
   input  logic        m_rdata_valid,
   output logic        m_rdata_ack,
   // statistics
   output logic [31:0] conflict_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      I_REQ,
      I_RSP,
      D_REQ,
      D_RSP
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   d_pend;
   logic   d_sel;
   logic   conflict;

   // request decode shared by arbitration and the conflict counter
   always_comb begin
      d_pend   = d_read | d_write;
      conflict = ~rst & (state == IDLE) & i_req_valid & d_pend;
   end

`ifdef ARB_RR_EN
   // last_grant: 0 = instruction granted last, 1 = data granted last
   logic last_grant;

   // on conflict the side that was not granted last wins
   always_comb begin
      d_sel = d_pend & (~i_req_valid | ~last_grant);
   end

   // remember which side was granted when leaving IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b0;
      end else if (state == IDLE) begin
         if (state_nxt == D_REQ) begin
            last_grant <= 1'b1;
         end else if (state_nxt == I_REQ) begin
            last_grant <= 1'b0;
         end
      end
   end
`else
   // fixed priority: any pending data request wins
   always_comb begin
      d_sel = d_pend;
   end
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // count IDLE cycles where both requesters are pending; wraps naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (conflict) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end

   // next-state and port steering; outputs held at zero while rst is high
   // so an abandoned transaction never leaks an ack or response
   always_comb begin
      state_nxt     = state;
      i_req_ack     = 1'b0;
      i_rdata       = '0;
      i_rdata_valid = 1'b0;
      d_req_ack     = 1'b0;
      d_rdata       = '0;
      d_rdata_valid = 1'b0;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_addr        = '0;
      m_wdata       = '0;
      m_wstrb       = '0;
      m_rdata_ack   = 1'b0;

      if (rst) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (d_sel) begin
                  state_nxt = D_REQ;
               end else if (i_req_valid) begin
                  state_nxt = I_REQ;
               end
            end
            I_REQ: begin
               if (i_req_valid) begin
                  m_read    = 1'b1;
                  m_addr    = i_addr;
                  i_req_ack = m_req_ack;
                  if (m_req_ack) begin
                     state_nxt = I_RSP;
                  end
               end else begin
                  state_nxt = IDLE;
               end
            end
            I_RSP: begin
               i_rdata       = m_rdata;
               i_rdata_valid = m_rdata_valid;
               m_rdata_ack   = i_rdata_ack;
               if (m_rdata_valid && i_rdata_ack) begin
                  state_nxt = IDLE;
               end
            end
            D_REQ: begin
               if (d_pend) begin
                  m_addr    = d_addr;
                  m_wdata   = d_wdata;
                  m_wstrb   = d_wstrb;
                  m_write   = d_write;
                  m_read    = d_read & ~d_write;
                  d_req_ack = m_req_ack;
                  if (m_req_ack) begin
                     // stores complete on acceptance; loads wait for data
                     state_nxt = d_write ? IDLE : D_RSP;
                  end
               end else begin
                  state_nxt = IDLE;
               end
            end
            D_RSP: begin
               d_rdata       = m_rdata;
               d_rdata_valid = m_rdata_valid;
               m_rdata_ack   = d_rdata_ack;
               if (m_rdata_valid && d_rdata_ack) begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change 1 time
// unit after each rising edge; outputs are sampled 1 unit later.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid;
   logic [31:0] i_addr;
   logic        i_req_ack;
   logic [31:0] i_rdata;
   logic        i_rdata_valid;
   logic        i_rdata_ack;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_req_ack;
   logic [31:0] d_rdata;
   logic        d_rdata_valid;
   logic        d_rdata_ack;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_req_ack;
   logic [31:0] m_rdata;
   logic        m_rdata_valid;
   logic        m_rdata_ack;
   logic [31:0] conflict_cnt;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .i_req_valid   (i_req_valid),
      .i_addr        (i_addr),
      .i_req_ack     (i_req_ack),
      .i_rdata       (i_rdata),
      .i_rdata_valid (i_rdata_valid),
      .i_rdata_ack   (i_rdata_ack),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_addr        (d_addr),
      .d_wdata       (d_wdata),
      .d_wstrb       (d_wstrb),
      .d_req_ack     (d_req_ack),
      .d_rdata       (d_rdata),
      .d_rdata_valid (d_rdata_valid),
      .d_rdata_ack   (d_rdata_ack),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_addr        (m_addr),
      .m_wdata       (m_wdata),
      .m_wstrb       (m_wstrb),
      .m_req_ack     (m_req_ack),
      .m_rdata       (m_rdata),
      .m_rdata_valid (m_rdata_valid),
      .m_rdata_ack   (m_rdata_ack),
      .conflict_cnt  (conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      i_req_valid   = 1'b0;
      i_addr        = '0;
      i_rdata_ack   = 1'b0;
      d_read        = 1'b0;
      d_write       = 1'b0;
      d_addr        = '0;
      d_wdata       = '0;
      d_wstrb       = '0;
      d_rdata_ack   = 1'b0;
      m_req_ack     = 1'b0;
      m_rdata       = '0;
      m_rdata_valid = 1'b0;
   endtask

   // one conflict round: both sides request a load in the same cycle;
   // dw says whether the data side is expected to win
   task automatic conflict_round(input string tag, input logic dw);
      i_req_valid = 1'b1;
      i_addr      = 32'h0000_0400;
      d_read      = 1'b1;
      d_addr      = 32'h0000_0500;
      settle();
      check({tag, "_latency_m_read"}, {31'd0, m_read}, 32'd0);
      tick();
      check({tag, "_m_addr"}, m_addr, dw ? 32'h0000_0500 : 32'h0000_0400);
      check({tag, "_m_read"}, {31'd0, m_read}, 32'd1);
      m_req_ack = 1'b1;
      settle();
      check({tag, "_d_req_ack"}, {31'd0, d_req_ack}, {31'd0, dw});
      check({tag, "_i_req_ack"}, {31'd0, i_req_ack}, {31'd0, ~dw});
      tick();
      m_req_ack     = 1'b0;
      i_req_valid   = 1'b0;
      d_read        = 1'b0;
      m_rdata       = 32'hCAFE_0001;
      m_rdata_valid = 1'b1;
      i_rdata_ack   = 1'b1;
      d_rdata_ack   = 1'b1;
      settle();
      check({tag, "_d_rdata_valid"}, {31'd0, d_rdata_valid}, {31'd0, dw});
      check({tag, "_i_rdata_valid"}, {31'd0, i_rdata_valid}, {31'd0, ~dw});
      check({tag, "_d_rdata"}, d_rdata, dw ? 32'hCAFE_0001 : 32'h0);
      check({tag, "_i_rdata"}, i_rdata, dw ? 32'h0 : 32'hCAFE_0001);
      tick();
      clear_inputs();
      settle();
      check({tag, "_idle_m_read"}, {31'd0, m_read}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic round2_data;
`ifdef ARB_RR_EN
      round2_data = 1'b0;
`else
      round2_data = 1'b1;
`endif
      clear_inputs();

      // reset with requests asserted: nothing may be issued or counted
      rst         = 1'b1;
      i_req_valid = 1'b1;
      d_read      = 1'b1;
      tick();
      tick();
      check("rst_m_read", {31'd0, m_read}, 32'd0);
      check("rst_m_write", {31'd0, m_write}, 32'd0);
      check("rst_conflict_cnt", conflict_cnt, 32'd0);
      check("rst_d_req_ack", {31'd0, d_req_ack}, 32'd0);
      clear_inputs();
      rst = 1'b0;
      tick();
      check("post_rst_m_read", {31'd0, m_read}, 32'd0);
      check("post_rst_conflict_cnt", conflict_cnt, 32'd0);

      // instruction fetch, memory accepts after two cycles
      i_req_valid = 1'b1;
      i_addr      = 32'h0000_0100;
      settle();
      check("fetch_latency_m_read", {31'd0, m_read}, 32'd0);
      tick();
      check("fetch_m_read", {31'd0, m_read}, 32'd1);
      check("fetch_m_addr", m_addr, 32'h0000_0100);
      check("fetch_m_write", {31'd0, m_write}, 32'd0);
      check("fetch_m_wstrb", {28'd0, m_wstrb}, 32'd0);
      check("fetch_no_ack", {31'd0, i_req_ack}, 32'd0);
      tick();
      m_req_ack = 1'b1;
      settle();
      check("fetch_i_req_ack", {31'd0, i_req_ack}, 32'd1);
      tick();
      m_req_ack     = 1'b0;
      i_req_valid   = 1'b0;
      m_rdata       = 32'h2402_0005;
      m_rdata_valid = 1'b1;
      i_rdata_ack   = 1'b1;
      settle();
      check("fetch_i_rdata", i_rdata, 32'h2402_0005);
      check("fetch_i_rdata_valid", {31'd0, i_rdata_valid}, 32'd1);
      check("fetch_m_rdata_ack", {31'd0, m_rdata_ack}, 32'd1);
      check("fetch_rsp_m_read", {31'd0, m_read}, 32'd0);
      tick();
      m_rdata_valid = 1'b0;
      i_rdata_ack   = 1'b0;
      settle();
      check("fetch_idle_i_rdata", i_rdata, 32'd0);
      check("fetch_idle_m_read", {31'd0, m_read}, 32'd0);
      clear_inputs();

      // store: no response phase, stray m_rdata_valid afterwards is ignored
      d_write = 1'b1;
      d_addr  = 32'h0000_0200;
      d_wdata = 32'hDEAD_BEEF;
      d_wstrb = 4'hF;
      tick();
      check("store_m_write", {31'd0, m_write}, 32'd1);
      check("store_m_read", {31'd0, m_read}, 32'd0);
      check("store_m_addr", m_addr, 32'h0000_0200);
      check("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
      check("store_m_wstrb", {28'd0, m_wstrb}, 32'h0000_000F);
      m_req_ack = 1'b1;
      settle();
      check("store_d_req_ack", {31'd0, d_req_ack}, 32'd1);
      tick();
      clear_inputs();
      m_rdata       = 32'h5555_AAAA;
      m_rdata_valid = 1'b1;
      d_rdata_ack   = 1'b1;
      settle();
      check("store_idle_m_write", {31'd0, m_write}, 32'd0);
      check("store_no_rsp_valid", {31'd0, d_rdata_valid}, 32'd0);
      check("store_no_rsp_data", d_rdata, 32'd0);
      check("stray_m_rdata_ack", {31'd0, m_rdata_ack}, 32'd0);
      tick();
      check("store_stay_idle_valid", {31'd0, d_rdata_valid}, 32'd0);
      clear_inputs();

      // read and write together: handled as a store
      d_read  = 1'b1;
      d_write = 1'b1;
      d_addr  = 32'h0000_0300;
      d_wdata = 32'h1234_5678;
      d_wstrb = 4'h3;
      tick();
      check("rw_m_write", {31'd0, m_write}, 32'd1);
      check("rw_m_read", {31'd0, m_read}, 32'd0);
      check("rw_m_wstrb", {28'd0, m_wstrb}, 32'h0000_0003);
      m_req_ack = 1'b1;
      tick();
      clear_inputs();
      m_rdata_valid = 1'b1;
      d_rdata_ack   = 1'b1;
      settle();
      check("rw_no_rsp_valid", {31'd0, d_rdata_valid}, 32'd0);
      check("rw_idle_m_write", {31'd0, m_write}, 32'd0);
      clear_inputs();

      // fetch withdrawn before acceptance: no ack, back to IDLE
      i_req_valid = 1'b1;
      i_addr      = 32'h0000_0700;
      tick();
      i_req_valid = 1'b0;
      m_req_ack   = 1'b1;
      settle();
      check("withdraw_no_ack", {31'd0, i_req_ack}, 32'd0);
      tick();
      m_rdata_valid = 1'b1;
      i_rdata_ack   = 1'b1;
      settle();
      check("withdraw_idle_m_read", {31'd0, m_read}, 32'd0);
      check("withdraw_no_rsp", {31'd0, i_rdata_valid}, 32'd0);
      clear_inputs();
      tick();

      // two back-to-back conflicts
      conflict_round("conf1", 1'b1);
      conflict_round("conf2", round2_data);
      check("conflict_cnt_two", conflict_cnt, 32'd2);

      // reset during a load response: response is dropped
      d_read = 1'b1;
      d_addr = 32'h0000_0600;
      tick();
      m_req_ack = 1'b1;
      tick();
      m_req_ack     = 1'b0;
      d_read        = 1'b0;
      m_rdata       = 32'h1111_2222;
      m_rdata_valid = 1'b1;
      d_rdata_ack   = 1'b1;
      rst           = 1'b1;
      settle();
      check("rst_rsp_d_rdata_valid", {31'd0, d_rdata_valid}, 32'd0);
      check("rst_rsp_m_rdata_ack", {31'd0, m_rdata_ack}, 32'd0);
      tick();
      rst = 1'b0;
      settle();
      check("rst_rsp_after_valid", {31'd0, d_rdata_valid}, 32'd0);
      check("rst_rsp_conflict_cnt", conflict_cnt, 32'd0);
      tick();
      check("rst_rsp_idle_valid", {31'd0, d_rdata_valid}, 32'd0);
      check("rst_rsp_idle_m_read", {31'd0, m_read}, 32'd0);
      clear_inputs();

      // counter wrap from all-ones
      force dut.conflict_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.conflict_cnt;
      #1;
      check("wrap_preload", conflict_cnt, 32'hFFFF_FFFF);
      i_req_valid = 1'b1;
      d_read      = 1'b1;
      tick();
      check("wrap_to_zero", conflict_cnt, 32'd0);
      clear_inputs();
      tick();
      tick();
      check("wrap_hold", conflict_cnt, 32'd0);
      check("wrap_idle_m_read", {31'd0, m_read}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
